// File: rtl/serv_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) on the SERV data bus, with a level timer interrupt.
// Define MTIMER_LATCH_EN to latch mtime[63:32] on a mtime_lo read for coherent 64-bit reads.
module serv_mtimer #(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_timer_irq
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    ADR_MTIME_LO = 2'd0,
    ADR_MTIME_HI = 2'd1,
    ADR_CMP_LO   = 2'd2,
    ADR_CMP_HI   = 2'd3
  } reg_adr_e;

  logic [CW-1:0] presc_cnt;
  logic [63:0]   mtime, mtime_nxt;
  logic [63:0]   mtimecmp, mtimecmp_nxt;
  logic [31:0]   rd_data;
  logic          tick, req, wr, rd;
  reg_adr_e      adr;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] v;
    v = old_val;
    for (int b = 0; b < 4; b++)
      if (sel[b]) v[8*b +: 8] = new_val[8*b +: 8];
    return v;
  endfunction

  assign adr  = reg_adr_e'(i_wb_adr);
  assign tick = (presc_cnt == CW'(PRESCALE - 1));
  // A request is accepted on the edge that raises ack; the cycle after ack is never a request.
  assign req  = i_wb_cyc & ~o_wb_ack;
  assign wr   = req & i_wb_we & (|i_wb_sel);
  assign rd   = req & ~i_wb_we;

`ifdef MTIMER_LATCH_EN
  logic [31:0] shadow;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mtime_nxt    = tick ? mtime + 64'd1 : mtime;
    mtimecmp_nxt = mtimecmp;
    if (wr) begin
      // A CPU write overrides the tick for the whole register: the other half sees no carry.
      unique case (adr)
        ADR_MTIME_LO: mtime_nxt = {mtime[63:32], byte_merge(mtime[31:0], i_wb_dat, i_wb_sel)};
        ADR_MTIME_HI: mtime_nxt = {byte_merge(mtime[63:32], i_wb_dat, i_wb_sel), mtime[31:0]};
        ADR_CMP_LO:   mtimecmp_nxt = {mtimecmp[63:32],
                                      byte_merge(mtimecmp[31:0], i_wb_dat, i_wb_sel)};
        ADR_CMP_HI:   mtimecmp_nxt = {byte_merge(mtimecmp[63:32], i_wb_dat, i_wb_sel),
                                      mtimecmp[31:0]};
        default:      ;
      endcase
    end
  end

  always_comb begin
    rd_data = 32'd0;
    unique case (adr)
      ADR_MTIME_LO: rd_data = mtime[31:0];
`ifdef MTIMER_LATCH_EN
      ADR_MTIME_HI: rd_data = shadow;
`else
      ADR_MTIME_HI: rd_data = mtime[63:32];
`endif
      ADR_CMP_LO:   rd_data = mtimecmp[31:0];
      ADR_CMP_HI:   rd_data = mtimecmp[63:32];
      default:      ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_cnt   <= '0;
      mtime       <= 64'd0;
      mtimecmp    <= CMP_RESET;
      o_wb_ack    <= 1'b0;
      o_wb_rdt    <= 32'd0;
      o_timer_irq <= 1'b0;
    end else begin
      presc_cnt   <= tick ? '0 : presc_cnt + CW'(1);
      mtime       <= mtime_nxt;
      mtimecmp    <= mtimecmp_nxt;
      o_wb_ack    <= req;
      o_timer_irq <= (mtime >= mtimecmp);
      if (rd) o_wb_rdt <= rd_data;
    end
  end

`ifdef MTIMER_LATCH_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                           shadow <= 32'd0;
    else if (rd && adr == ADR_MTIME_LO)     shadow <= mtime[63:32];
  end
`endif

endmodule

// File: tb/tb_serv_mtimer.sv
// Bench for serv_mtimer: directed and random bus traffic scored against a cycle-level
// reference model of the timer; a monitor pops expected responses on every DUT ack.
module tb_serv_mtimer;

  localparam int unsigned PRESCALE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  adr = 2'd0;
  logic [31:0] dat = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] rdt;
  logic        ack;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  // Reference state
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic [31:0] m_shadow;
  logic        m_ack;
  logic        m_irq;
  int          m_cycle;

  serv_mtimer #(.PRESCALE(PRESCALE)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_we(we), .i_wb_adr(adr),
    .i_wb_dat(dat), .i_wb_sel(sel), .o_wb_rdt(rdt), .o_wb_ack(ack), .o_timer_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] apply_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] be);
    logic [31:0] v;
    v = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) v[8*b +: 8] = new_v[8*b +: 8];
    return v;
  endfunction

  // Reference model: mtime counts cycles since reset divided by PRESCALE; bus accesses act
  // on the values held before the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mtime = 64'd0; m_cmp = '1; m_shadow = 32'd0;
      m_ack = 1'b0; m_irq = 1'b0; m_cycle = 0;
      sb.delete();
    end else begin
      logic [63:0] t_new;
      logic [63:0] c_new;
      logic [31:0] s_new;
      logic [31:0] rv;
      bit          accept;
      accept = cyc && !m_ack;
      t_new  = ((m_cycle % PRESCALE) == PRESCALE - 1) ? m_mtime + 64'd1 : m_mtime;
      c_new  = m_cmp;
      s_new  = m_shadow;
      if (accept && !we) begin
        case (adr)
          2'd0: begin rv = m_mtime[31:0]; s_new = m_mtime[63:32]; end
`ifdef MTIMER_LATCH_EN
          2'd1: rv = m_shadow;
`else
          2'd1: rv = m_mtime[63:32];
`endif
          2'd2: rv = m_cmp[31:0];
          default: rv = m_cmp[63:32];
        endcase
        sb.push_back('{is_rd: 1'b1, data: rv});
      end else if (accept) begin
        sb.push_back('{is_rd: 1'b0, data: 32'd0});
        if (sel != 4'd0) begin
          case (adr)
            2'd0: t_new = {m_mtime[63:32], apply_bytes(m_mtime[31:0], dat, sel)};
            2'd1: t_new = {apply_bytes(m_mtime[63:32], dat, sel), m_mtime[31:0]};
            2'd2: c_new = {m_cmp[63:32], apply_bytes(m_cmp[31:0], dat, sel)};
            default: c_new = {apply_bytes(m_cmp[63:32], dat, sel), m_cmp[31:0]};
          endcase
        end
      end
      m_irq    = (m_mtime >= m_cmp);
      m_ack    = accept;
      m_mtime  = t_new;
      m_cmp    = c_new;
`ifdef MTIMER_LATCH_EN
      m_shadow = s_new;
`endif
      m_cycle++;
    end
  end

  // Monitor: compares handshake and irq every cycle, and pops the scoreboard on each ack.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ack", ack, m_ack);
      check("irq", irq, m_irq);
      if (ack) begin
        check("sb_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          if (e.is_rd) check("rdt", rdt, e.data);
        end
      end
    end
  end

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r);
    @(negedge clk);
    cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) break;
    end
    check("bus_ack_seen", ack, 1);
    r   = rdt;
    cyc = 1'b0; we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc = 1'b0; rst_n = 1'b0;
    #1;
    check("rst_ack", ack, 0);
    check("rst_rdt", rdt, 0);
    check("rst_irq", irq, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;

    // Idle count-up after reset; irq must stay low with the all-ones compare value.
    do_reset();
    repeat (30) @(negedge clk);
    check("idle_irq", irq, 0);
    bus(1'b0, 2'd0, 32'd0, 4'd0, r);

    // Compare match then clear with the all-ones value.
    do_reset();
    bus(1'b1, 2'd3, 32'd0, 4'hF, r);
    bus(1'b1, 2'd2, 32'd20, 4'hF, r);
    repeat (70) @(negedge clk);
    check("cmp_irq_high", irq, 1);
    bus(1'b1, 2'd2, 32'hFFFF_FFFF, 4'hF, r);
    bus(1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF, r);
    repeat (3) @(negedge clk);
    check("cmp_irq_low", irq, 0);

    // Low-word carry into the high word, and lo-then-hi read ordering.
    bus(1'b1, 2'd0, 32'hFFFF_FFFE, 4'hF, r);
    bus(1'b1, 2'd1, 32'd0, 4'hF, r);
    repeat (10) @(negedge clk);
    bus(1'b0, 2'd1, 32'd0, 4'd0, r);
    check("carry_hi", r, 1);
    bus(1'b1, 2'd0, 32'hFFFF_FFFF, 4'hF, r);
    bus(1'b1, 2'd1, 32'd0, 4'hF, r);
    bus(1'b0, 2'd0, 32'd0, 4'd0, r);
    bus(1'b0, 2'd1, 32'd0, 4'd0, r);

    // mtime wrapping to zero drops irq unless mtimecmp is zero.
    bus(1'b1, 2'd2, 32'd5, 4'hF, r);
    bus(1'b1, 2'd3, 32'd0, 4'hF, r);
    bus(1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF, r);
    bus(1'b1, 2'd0, 32'hFFFF_FFFF, 4'hF, r);
    repeat (12) @(negedge clk);

    // Byte-lane write to cmp_lo.
    bus(1'b1, 2'd2, 32'h1122_3344, 4'hF, r);
    bus(1'b1, 2'd2, 32'h0000_AB00, 4'b0010, r);
    bus(1'b0, 2'd2, 32'd0, 4'd0, r);
    check("byte_write", r, 32'h1122_AB44);
    bus(1'b1, 2'd2, 32'hDEAD_BEEF, 4'b0000, r);
    bus(1'b0, 2'd2, 32'd0, 4'd0, r);
    check("sel_zero", r, 32'h1122_AB44);

    // Back-to-back: cyc held four clocks yields ack 0,1,0,1.
    @(negedge clk);
    cyc = 1'b1; we = 1'b0; adr = 2'd0;
    @(negedge clk); check("b2b_ack1", ack, 1); adr = 2'd2;
    @(negedge clk); check("b2b_ack2", ack, 0);
    @(negedge clk); check("b2b_ack3", ack, 1);
    check("b2b_rdt", rdt, 32'h1122_AB44);
    cyc = 1'b0;

    // Reset while ack and irq are high.
    bus(1'b1, 2'd3, 32'd0, 4'hF, r);
    bus(1'b1, 2'd2, 32'd0, 4'hF, r);
    repeat (3) @(negedge clk);
    cyc = 1'b1; adr = 2'd3;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ack", ack, 0);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_rdt", rdt, 0);
    cyc = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus(1'b0, 2'd0, 32'd0, 4'd0, r);
    bus(1'b0, 2'd1, 32'd0, 4'd0, r);
    check("post_rst_hi", r, 0);

    // Random traffic, compare registers biased toward the live mtime range.
    for (int n = 0; n < 300; n++) begin
      logic [1:0] a;
      logic [31:0] d;
      a = 2'($urandom_range(0, 3));
      d = $urandom();
      if (a == 2'd1 || a == 2'd3) d = 32'($urandom_range(0, 2));
      bus(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)), r);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
